mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: an instruction-fetch port and a data port share one memory
// port. Alternates on ties, latches the winning request, and aborts a read that never returns.
module mem_arbiter #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction-fetch requester
    input  logic                  if_req_i,
    input  logic [WORD_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [WORD_WIDTH-1:0] if_rdata_o,
    // data requester
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [WORD_WIDTH-1:0] d_addr_i,
    input  logic [WORD_WIDTH-1:0] d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [WORD_WIDTH-1:0] d_rdata_o,
    // memory side
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [WORD_WIDTH-1:0] mem_addr_o,
    output logic [WORD_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [WORD_WIDTH-1:0] mem_rdata_i,
    // status
    output logic                  busy_o,
    output logic                  err_o
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StIfReq,
        StIfWait,
        StDReq,
        StDWait
    } state_e;

    state_e                state_q, state_d;
    logic                  last_d_q, last_d_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;

    logic                  timed_out;

    // Counter has sat in WAIT for TIMEOUT cycles with no response.
    assign timed_out = (cnt_q == TimeoutCnt) && !mem_rvalid_i;

    // State register and latched transaction; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            last_d_q <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
        end
    end

    // Next-state: arbitration in IDLE, grant handshake in REQ, response or timeout in WAIT.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        err_d    = err_q;

        case (state_q)
            StIdle: begin
                if (mem_rvalid_i) begin
                    err_d = 1'b1;
                end
                // Data wins unless fetch is also requesting and data went last.
                if (d_req_i && (!if_req_i || !last_d_q)) begin
                    state_d  = StDReq;
                    last_d_d = 1'b1;
                    addr_d   = d_addr_i;
                    we_d     = d_we_i;
                    wdata_d  = d_wdata_i;
                end else if (if_req_i) begin
                    state_d  = StIfReq;
                    last_d_d = 1'b0;
                    addr_d   = if_addr_i;
                    we_d     = 1'b0;
                end
            end
            StIfReq, StDReq: begin
                if (mem_rvalid_i) begin
                    err_d = 1'b1;
                end
                if (mem_gnt_i) begin
                    state_d = (state_q == StIfReq) ? StIfWait : StDWait;
                    cnt_d   = '0;
                end
            end
            StIfWait, StDWait: begin
                if (mem_rvalid_i) begin
                    state_d = StIdle;
                end else if (cnt_q == TimeoutCnt) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory request is driven purely from the state and latched registers.
    assign mem_req_o   = (state_q == StIfReq) || (state_q == StDReq);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    // Requester handshakes are combinational so grants and responses pass through same cycle.
    assign if_gnt_o    = (state_q == StIfReq) && mem_gnt_i;
    assign d_gnt_o     = (state_q == StDReq) && mem_gnt_i;
    assign if_rvalid_o = (state_q == StIfWait) && (mem_rvalid_i || timed_out);
    assign d_rvalid_o  = (state_q == StDWait) && (mem_rvalid_i || timed_out);
    assign if_rdata_o  = ((state_q == StIfWait) && mem_rvalid_i) ? mem_rdata_i : '0;
    assign d_rdata_o   = ((state_q == StDWait) && mem_rvalid_i) ? mem_rdata_i : '0;

    assign busy_o = (state_q != StIdle);
    assign err_o  = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter, plus hand sequences for timeout, reset and stray rvalid.
module tb_mem_arbiter;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         if_req_i, d_req_i, d_we_i, mem_gnt_i, mem_rvalid_i;
    logic [W-1:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
    logic         if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o;
    logic         mem_req_o, mem_we_o, busy_o, err_o;
    logic [W-1:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;

    mem_arbiter #(
        .WORD_WIDTH(W),
        .TIMEOUT   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_gnt_o     (d_gnt_o),
        .d_rvalid_o  (d_rvalid_o),
        .d_rdata_o   (d_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         if_req;
        logic [W-1:0] if_addr;
        logic         d_req;
        logic         d_we;
        logic [W-1:0] d_addr;
        logic [W-1:0] d_wdata;
        logic         mem_gnt;
        logic         mem_rvalid;
        logic [W-1:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic         mem_req;
        logic         mem_we;
        logic [W-1:0] mem_addr;
        logic [W-1:0] mem_wdata;
        logic         if_gnt;
        logic         if_rvalid;
        logic [W-1:0] if_rdata;
        logic         d_gnt;
        logic         d_rvalid;
        logic [W-1:0] d_rdata;
        logic         busy;
        logic         err;
    } out_t;

    typedef struct {
        string name;
        in_t   stim;
        out_t  exp;
    } vec_t;

    vec_t vecs[$];
    out_t act;
    int   n_vec  = 0;
    int   n_miss = 0;

    assign act = {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_gnt_o, if_rvalid_o,
                  if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o, busy_o, err_o};

    function automatic in_t mk_in(input logic ir, input logic [W-1:0] ia, input logic dr,
                                  input logic dwe, input logic [W-1:0] da,
                                  input logic [W-1:0] dwd, input logic g, input logic rv,
                                  input logic [W-1:0] rd);
        in_t s;
        s = {ir, ia, dr, dwe, da, dwd, g, rv, rd};
        return s;
    endfunction

    function automatic out_t mk_out(input logic req, input logic we, input logic [W-1:0] addr,
                                    input logic [W-1:0] wd, input logic ig, input logic iv,
                                    input logic [W-1:0] ird, input logic dg, input logic dv,
                                    input logic [W-1:0] drd, input logic bsy,
                                    input logic er);
        out_t o;
        o = {req, we, addr, wd, ig, iv, ird, dg, dv, drd, bsy, er};
        return o;
    endfunction

    task automatic add(input string n, input in_t s, input out_t e);
        vec_t v;
        v.name = n;
        v.stim = s;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic apply(input in_t s);
        if_req_i     = s.if_req;
        if_addr_i    = s.if_addr;
        d_req_i      = s.d_req;
        d_we_i       = s.d_we;
        d_addr_i     = s.d_addr;
        d_wdata_i    = s.d_wdata;
        mem_gnt_i    = s.mem_gnt;
        mem_rvalid_i = s.mem_rvalid;
        mem_rdata_i  = s.mem_rdata;
    endtask

    task automatic check(input string name, input out_t got, input out_t want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check1(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [W-1:0] Z   = '0;
    localparam logic [W-1:0] IA  = 32'h0000_0300;
    localparam logic [W-1:0] DA  = 32'h0000_0200;
    localparam logic [W-1:0] DWD = 32'h1111_2222;
    localparam logic [W-1:0] SWD = 32'h1234_5678;

    in_t both;
    in_t both_g;
    in_t idle0;

    initial begin
        // Alternation after reset: D first, then IF, D, IF.
        both   = mk_in(1, IA, 1, 1, DA, DWD, 0, 0, Z);
        both_g = mk_in(1, IA, 1, 1, DA, DWD, 1, 0, Z);
        idle0  = mk_in(0, Z, 0, 0, Z, Z, 0, 0, Z);
        add("alt_idle0", both,   mk_out(0, 0, Z, Z, 0, 0, Z, 0, 0, Z, 0, 0));
        add("alt_d_gnt0", both_g, mk_out(1, 1, DA, DWD, 0, 0, Z, 1, 0, Z, 1, 0));
        add("alt_d_rv0", mk_in(1, IA, 1, 1, DA, DWD, 0, 1, 32'hC1),
            mk_out(0, 1, DA, DWD, 0, 0, Z, 0, 1, 32'hC1, 1, 0));
        add("alt_idle1", both,   mk_out(0, 1, DA, DWD, 0, 0, Z, 0, 0, Z, 0, 0));
        add("alt_if_gnt0", both_g, mk_out(1, 0, IA, DWD, 1, 0, Z, 0, 0, Z, 1, 0));
        add("alt_if_rv0", mk_in(1, IA, 1, 1, DA, DWD, 0, 1, 32'hC2),
            mk_out(0, 0, IA, DWD, 0, 1, 32'hC2, 0, 0, Z, 1, 0));
        add("alt_idle2", both,   mk_out(0, 0, IA, DWD, 0, 0, Z, 0, 0, Z, 0, 0));
        add("alt_d_gnt1", both_g, mk_out(1, 1, DA, DWD, 0, 0, Z, 1, 0, Z, 1, 0));
        add("alt_d_rv1", mk_in(1, IA, 1, 1, DA, DWD, 0, 1, 32'hC3),
            mk_out(0, 1, DA, DWD, 0, 0, Z, 0, 1, 32'hC3, 1, 0));
        add("alt_idle3", both,   mk_out(0, 1, DA, DWD, 0, 0, Z, 0, 0, Z, 0, 0));
        add("alt_if_gnt1", both_g, mk_out(1, 0, IA, DWD, 1, 0, Z, 0, 0, Z, 1, 0));
        add("alt_if_rv1", mk_in(1, IA, 1, 1, DA, DWD, 0, 1, 32'hC4),
            mk_out(0, 0, IA, DWD, 0, 1, 32'hC4, 0, 0, Z, 1, 0));
        add("alt_idle4", idle0,  mk_out(0, 0, IA, DWD, 0, 0, Z, 0, 0, Z, 0, 0));
        // Single fetch from 0x100, response two cycles after grant.
        add("if_idle", mk_in(1, 32'h100, 0, 0, Z, Z, 0, 0, Z),
            mk_out(0, 0, IA, DWD, 0, 0, Z, 0, 0, Z, 0, 0));
        add("if_gnt", mk_in(1, 32'h100, 0, 0, Z, Z, 1, 0, Z),
            mk_out(1, 0, 32'h100, DWD, 1, 0, Z, 0, 0, Z, 1, 0));
        add("if_wait", idle0, mk_out(0, 0, 32'h100, DWD, 0, 0, Z, 0, 0, Z, 1, 0));
        add("if_rvalid", mk_in(0, Z, 0, 0, Z, Z, 0, 1, 32'hDEAD_BEEF),
            mk_out(0, 0, 32'h100, DWD, 0, 1, 32'hDEAD_BEEF, 0, 0, Z, 1, 0));
        add("if_done", idle0, mk_out(0, 0, 32'h100, DWD, 0, 0, Z, 0, 0, Z, 0, 0));
        // Store to 0x40; address/data change and request drop after latching are ignored.
        add("st_idle", mk_in(0, Z, 1, 1, 32'h40, SWD, 0, 0, Z),
            mk_out(0, 0, 32'h100, DWD, 0, 0, Z, 0, 0, Z, 0, 0));
        add("st_hold", mk_in(0, Z, 0, 1, 32'h80, 32'hFFFF_FFFF, 0, 0, Z),
            mk_out(1, 1, 32'h40, SWD, 0, 0, Z, 0, 0, Z, 1, 0));
        add("st_gnt", mk_in(0, Z, 0, 1, 32'h80, 32'hFFFF_FFFF, 1, 0, Z),
            mk_out(1, 1, 32'h40, SWD, 0, 0, Z, 1, 0, Z, 1, 0));
        add("st_ack", mk_in(0, Z, 0, 1, 32'h80, 32'hFFFF_FFFF, 0, 1, 32'hA5A5_0001),
            mk_out(0, 1, 32'h40, SWD, 0, 0, Z, 0, 1, 32'hA5A5_0001, 1, 0));
        add("st_done", idle0, mk_out(0, 1, 32'h40, SWD, 0, 0, Z, 0, 0, Z, 0, 0));

        // Reset with every input active: all outputs must stay 0.
        rst = 1'b1;
        apply(mk_in(1, 32'h100, 1, 1, 32'h200, 32'h5, 1, 1, 32'hFFFF));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", act, '0);
        apply(idle0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].stim);
            @(negedge clk);
            check(vecs[i].name, act, vecs[i].exp);
            next_cycle();
        end

        // Fetch whose response never arrives: aborts on the fifth WAIT cycle.
        apply(mk_in(1, 32'h500, 0, 0, Z, Z, 0, 0, Z));
        next_cycle();
        apply(mk_in(0, Z, 0, 0, Z, Z, 1, 0, Z));
        @(negedge clk);
        check1("to_if_gnt", if_gnt_o, 1);
        next_cycle();
        apply(mk_in(0, Z, 0, 0, Z, Z, 0, 0, 32'hFFFF_FFFF));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check1("to_wait_no_rvalid", if_rvalid_o, 0);
            check1("to_wait_busy", busy_o, 1);
            next_cycle();
        end
        @(negedge clk);
        check1("to_rvalid", if_rvalid_o, 1);
        check1("to_rdata_zero", if_rdata_o, 0);
        check1("to_err_before", err_o, 0);
        next_cycle();
        check1("to_err_set", err_o, 1);
        check1("to_back_idle", busy_o, 0);
        next_cycle();
        check1("to_err_sticky", err_o, 1);

        // Reset during D_WAIT drops everything at once; pending fetch wins afterwards.
        apply(mk_in(0, Z, 1, 0, 32'h600, Z, 0, 0, Z));
        next_cycle();
        apply(mk_in(0, Z, 0, 0, Z, Z, 1, 0, Z));
        @(negedge clk);
        check1("rst_d_gnt", d_gnt_o, 1);
        next_cycle();
        apply(mk_in(1, 32'h700, 0, 0, Z, Z, 0, 1, 32'h77));
        #2;
        check1("rst_pre_rvalid", d_rvalid_o, 1);
        rst = 1'b1;
        #1;
        check1("rst_mem_req", mem_req_o, 0);
        check1("rst_d_rvalid", d_rvalid_o, 0);
        check1("rst_d_rdata", d_rdata_o, 0);
        check1("rst_busy", busy_o, 0);
        check1("rst_err_clr", err_o, 0);
        apply(mk_in(1, 32'h700, 0, 0, Z, Z, 0, 0, Z));
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        check1("rst_if_wins_req", mem_req_o, 1);
        check1("rst_if_wins_addr", mem_addr_o, 32'h700);
        // Grant and rvalid together in a REQ state: grant taken, rvalid flagged as error.
        apply(mk_in(0, Z, 0, 0, Z, Z, 1, 1, 32'h55));
        @(negedge clk);
        check1("both_if_gnt", if_gnt_o, 1);
        check1("both_no_rvalid", if_rvalid_o, 0);
        check1("both_d_gnt", d_gnt_o, 0);
        next_cycle();
        check1("both_in_wait", busy_o, 1);
        check1("both_err", err_o, 1);
        apply(mk_in(0, Z, 0, 0, Z, Z, 0, 1, 32'h99));
        @(negedge clk);
        check1("both_rdata", if_rdata_o, 32'h99);
        next_cycle();

        // Stray rvalid in IDLE: ignored, but flags an error.
        rst = 1'b1;
        apply(idle0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        apply(mk_in(0, Z, 0, 0, Z, Z, 0, 1, 32'h1234));
        @(negedge clk);
        check1("idle_rv_if", if_rvalid_o, 0);
        check1("idle_rv_d", d_rvalid_o, 0);
        check1("idle_rv_rdata", if_rdata_o | d_rdata_o, 0);
        check1("idle_rv_err_pre", err_o, 0);
        next_cycle();
        apply(idle0);
        check1("idle_rv_err", err_o, 1);
        check1("idle_rv_busy", busy_o, 0);
        repeat (3) next_cycle();
        check1("idle_rv_err_sticky", err_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
